// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the RV32I core.
// Holds the NOP encoding used for IF/ID bubbles and the fetch FSM states.
package riscv_pkg;

  localparam int          DEFAULT_DATA_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: loads a fetched instruction or a bubble, holds when disabled.
// Latency: 1 cycle. Backpressure: i_en low holds contents; i_flush overrides and loads a bubble.
// Reset: asynchronous, active-high, to a bubble.
module if_id_register
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_flush,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_pcplus4,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pcplus4,
  output logic                  o_vld
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_pcplus4;
  logic                  r_vld;

  // An enabled cycle with no instruction available loads a bubble so nothing executes twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr   <= NOP;
      r_pc      <= '0;
      r_pcplus4 <= '0;
      r_vld     <= 1'b0;
    end else if (i_flush || (i_en && !i_vld)) begin
      r_instr   <= NOP;
      r_pc      <= '0;
      r_pcplus4 <= '0;
      r_vld     <= 1'b0;
    end else if (i_en) begin
      r_instr   <= i_instr;
      r_pc      <= i_pc;
      r_pcplus4 <= i_pcplus4;
      r_vld     <= 1'b1;
    end
  end

  assign o_instr   = r_instr;
  assign o_pc      = r_pc;
  assign o_pcplus4 = r_pcplus4;
  assign o_vld     = r_vld;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PCF, issues one outstanding imem request, drives IF/ID; FETCH_PERF_COUNTERS_EN adds counters.
// Latency: imem latency + 1 cycle request-to-IF/ID, so a 1-cycle memory yields 1 instruction per 2 cycles.
// Backpressure: StallFetch/StallDecode park a returned instruction in HoldBuf; FetchBusy flags nothing to advance.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallFetch,
  input  logic                  StallDecode,
  input  logic                  FlushDecode,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  ImemReqValid,
  output logic [DATA_WIDTH-1:0] ImemReqAddr,
  input  logic                  ImemReqReady,
  input  logic                  ImemRspValid,
  input  logic [DATA_WIDTH-1:0] ImemRspData,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0]           FetchCount,
  output logic [31:0]           BubbleCount,
  output logic [31:0]           DropCount,
`endif
  output logic                  FetchBusy
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pcf;
  logic [DATA_WIDTH-1:0] w_pcf_nxt;
  logic [DATA_WIDTH-1:0] r_hold_buf;
  logic [DATA_WIDTH-1:0] w_hold_buf_nxt;
  logic                  r_drop;
  logic                  w_drop_nxt;
  logic                  r_req_en;
  logic                  w_req_fire;
  logic                  w_rsp_live;
  logic                  w_avail;
  logic                  w_load;
  logic                  w_outstanding;
  logic [DATA_WIDTH-1:0] w_pcf_plus4;

  assign w_pcf_plus4 = r_pcf + PC_STEP;
  assign w_req_fire  = ImemReqValid & ImemReqReady;
  assign w_rsp_live  = (r_state == WAIT) & ImemRspValid & ~r_drop;
  assign w_avail     = w_rsp_live | (r_state == HOLD);
  // A redirect cancels whatever is available this cycle, so it never reaches IF/ID.
  assign w_load      = w_avail & ~StallDecode & ~StallFetch & ~PCSrcE;
  assign w_outstanding = ((r_state == WAIT) & ~ImemRspValid) | ((r_state == REQ) & w_req_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= REQ;
      r_pcf      <= RESET_PC;
      r_hold_buf <= '0;
      r_drop     <= 1'b0;
      r_req_en   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pcf      <= w_pcf_nxt;
      r_hold_buf <= w_hold_buf_nxt;
      r_drop     <= w_drop_nxt;
      r_req_en   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pcf_nxt      = r_pcf;
    w_hold_buf_nxt = r_hold_buf;
    w_drop_nxt     = r_drop;
    case (r_state)
      REQ: begin
        if (w_req_fire) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (ImemRspValid) begin
          w_drop_nxt = 1'b0;
          if (r_drop) begin
            w_state_nxt = REQ;
          end else if (w_load) begin
            w_state_nxt = REQ;
            w_pcf_nxt   = w_pcf_plus4;
          end else begin
            w_hold_buf_nxt = ImemRspData;
            w_state_nxt    = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_load) begin
          w_state_nxt = REQ;
          w_pcf_nxt   = w_pcf_plus4;
        end
      end
      default: w_state_nxt = REQ;
    endcase
    // Redirect wins over everything; an in-flight request is tagged so its response is discarded.
    if (PCSrcE) begin
      w_pcf_nxt   = PCTargetE & ALIGN_MASK;
      w_drop_nxt  = w_outstanding;
      w_state_nxt = w_outstanding ? WAIT : REQ;
    end
  end

  assign ImemReqValid = r_req_en & (r_state == REQ);
  assign ImemReqAddr  = r_pcf;
  assign FetchBusy    = ~w_avail;

  if_id_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .i_en     (~StallDecode),
    .i_flush  (FlushDecode),
    .i_vld    (w_load),
    .i_instr  ((r_state == HOLD) ? r_hold_buf : ImemRspData),
    .i_pc     (r_pcf),
    .i_pcplus4(w_pcf_plus4),
    .o_instr  (InstrD),
    .o_pc     (PCD),
    .o_pcplus4(PCPlus4D),
    .o_vld    (ValidD)
  );

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_drop_cnt;
  logic        w_rsp_discard;

  assign w_rsp_discard = (r_state == WAIT) & ImemRspValid & (r_drop | PCSrcE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_load && !FlushDecode) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (FetchBusy) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_rsp_discard) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign FetchCount  = r_fetch_cnt;
  assign BubbleCount = r_bubble_cnt;
  assign DropCount   = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Random and directed bench for fetch_stage: latency-configurable imem model plus a program-order scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallFetch, StallDecode, FlushDecode, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReqValid, ImemReqReady, ImemRspValid;
  logic [31:0] ImemReqAddr, ImemRspData;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusy;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] FetchCount, BubbleCount, DropCount;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .StallFetch(StallFetch), .StallDecode(StallDecode), .FlushDecode(FlushDecode),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ImemReqValid(ImemReqValid), .ImemReqAddr(ImemReqAddr), .ImemReqReady(ImemReqReady),
    .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
`ifdef FETCH_PERF_COUNTERS_EN
    .FetchCount(FetchCount), .BubbleCount(BubbleCount), .DropCount(DropCount),
`endif
    .FetchBusy(FetchBusy)
  );

  int errors = 0;
  int checks = 0;
  int loads_total = 0;
  int loads_since_rst = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference: IF/ID must show the program in order, restarting at the aligned target on every redirect.
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; logic [31:0] pc4; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] model_pc;

  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    model_pc = {pc[31:2], 2'b00};
  endtask

  task automatic model_topup();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc    = model_pc;
      e.instr = mem_word(model_pc);
      e.pc4   = model_pc + 32'd4;
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
  endtask

  // Instruction memory: one request at a time, response exactly lat cycles after acceptance.
  int          lat = 1;
  int          ready_pct = 100;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr;
  logic [31:0] req_log[$];

  always @(negedge clk) begin : imem
    #1;
    if (rst) begin
      pend         = 1'b0;
      ImemRspValid = 1'b0;
      ImemReqReady = 1'b0;
      ImemRspData  = '0;
    end else begin
      ImemRspValid = 1'b0;
      ImemRspData  = $urandom();
      if (pend) begin
        if (cnt == 0) begin
          ImemRspValid = 1'b1;
          ImemRspData  = mem_word(pend_addr);
          pend         = 1'b0;
        end else begin
          cnt--;
        end
      end
      ImemReqReady = ($urandom_range(99) < ready_pct);
      if (ImemReqValid && ImemReqReady) begin
        pend      = 1'b1;
        cnt       = lat - 1;
        pend_addr = ImemReqAddr;
        req_log.push_back(ImemReqAddr);
      end
    end
  end

  // Monitor: compares every fresh IF/ID load against the scoreboard, and checks stall/flush behaviour.
  logic [31:0] prev_instr, prev_pc, prev_pc4;
  logic        prev_vld;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && !rst) begin
      if (ImemReqValid) begin
        chk("req_align", {30'd0, ImemReqAddr[1:0]}, 32'd0);
        chk("single_outstanding", {31'd0, pend}, 32'd0);
      end
      if (FlushDecode) begin
        chk("flush_instr", InstrD, NOP);
        chk("flush_vld", {31'd0, ValidD}, 32'd0);
      end else if (StallDecode) begin
        chk("stall_instr", InstrD, prev_instr);
        chk("stall_pc", PCD, prev_pc);
        chk("stall_vld", {31'd0, ValidD}, {31'd0, prev_vld});
      end else if (ValidD) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", PCD, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", PCD, e.pc);
          chk("sb_instr", InstrD, e.instr);
          chk("sb_pcplus4", PCPlus4D, e.pc4);
        end
        loads_total++;
        loads_since_rst++;
      end
    end
    prev_instr = InstrD;
    prev_pc    = PCD;
    prev_pc4   = PCPlus4D;
    prev_vld   = ValidD;
  end

  task automatic cyc();
    @(negedge clk);
    #2;
    model_topup();
  endtask

  task automatic redirect(input logic [31:0] tgt);
    PCSrcE      = 1'b1;
    FlushDecode = 1'b1;
    PCTargetE   = tgt;
    model_restart(tgt);
    model_topup();
    cyc();
    PCSrcE      = 1'b0;
    FlushDecode = 1'b0;
  endtask

  // Waits (bounded) until request number idx has been accepted and returns its address.
  task automatic wait_req(input int idx, input string name, output logic [31:0] addr);
    int k = 0;
    while (req_log.size() <= idx && k < 60) begin
      cyc();
      k++;
    end
    if (req_log.size() <= idx) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      addr = 'x;
    end else begin
      addr = req_log[idx];
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_instr"}, InstrD, NOP);
    chk({tag, "_pcd"}, PCD, 32'd0);
    chk({tag, "_pcplus4"}, PCPlus4D, 32'd0);
    chk({tag, "_vld"}, {31'd0, ValidD}, 32'd0);
    chk({tag, "_reqvld"}, {31'd0, ImemReqValid}, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk({tag, "_fetchcnt"}, FetchCount, 32'd0);
    chk({tag, "_bubblecnt"}, BubbleCount, 32'd0);
    chk({tag, "_dropcnt"}, DropCount, 32'd0);
`endif
  endtask

  initial begin : driver
    logic [31:0] a;
    int          n0;
    int          k;
    rst = 1'b1;
    StallFetch = 1'b0; StallDecode = 1'b0; FlushDecode = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    #12;
    reset_checks("reset");
    cyc();
    rst = 1'b0;
    model_restart(32'h0);
    model_topup();
    loads_since_rst = 0;
    mon_en = 1'b1;
    chk("reqvld_before_first_clk", {31'd0, ImemReqValid}, 32'd0);
    chk("busy_after_reset", {31'd0, FetchBusy}, 32'd1);

    // Clean stream with a 1-cycle memory: one instruction every two cycles.
    repeat (20) cyc();
    chk("throughput_1cyc", {31'd0, (loads_since_rst >= 8 && loads_since_rst <= 10)}, 32'd1);

    // Decode stall across the response: instruction parks in HoldBuf, then loads with nothing lost.
    wait_req(req_log.size(), "stall_req", a);
    StallDecode = 1'b1; StallFetch = 1'b1;
    cyc();
    cyc();
    chk("hold_busy", {31'd0, FetchBusy}, 32'd0);
    chk("hold_no_req", {31'd0, ImemReqValid}, 32'd0);
    cyc();
    StallDecode = 1'b0; StallFetch = 1'b0;
    repeat (6) cyc();

    // Flush and stall together: flush wins.
    k = 0;
    while (!ValidD && k < 20) begin cyc(); k++; end
    FlushDecode = 1'b1; StallDecode = 1'b1; StallFetch = 1'b1;
    cyc();
    chk("flush_stall_instr", InstrD, NOP);
    chk("flush_stall_vld", {31'd0, ValidD}, 32'd0);
    FlushDecode = 1'b0; StallDecode = 1'b0; StallFetch = 1'b0;

    // Redirect while a 4-cycle request is outstanding: old response dropped, refetch at target.
    lat = 4;
    n0 = req_log.size();
    wait_req(n0, "lat4_req", a);
    cyc();
    n0 = req_log.size();
    redirect(32'h0000_0100);
    wait_req(n0, "redirect_wait", a);
    chk("redirect_addr", a, 32'h0000_0100);
    repeat (12) cyc();

    // Unaligned target is word-aligned; PC wraps past the top of the address space.
    lat = 1;
    n0 = req_log.size();
    redirect(32'h0000_0103);
    wait_req(n0, "unaligned", a);
    chk("unaligned_addr", a, 32'h0000_0100);
    repeat (6) cyc();
    n0 = req_log.size();
    redirect(32'hFFFF_FFFC);
    wait_req(n0, "wrap_first", a);
    chk("wrap_first_addr", a, 32'hFFFF_FFFC);
    wait_req(n0 + 1, "wrap_next", a);
    chk("wrap_next_addr", a, 32'h0000_0000);
    repeat (6) cyc();

    // Randomised traffic: memory latency, ready, stalls and redirects.
    ready_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 4);
      StallDecode = ($urandom_range(99) < 20);
      StallFetch  = StallDecode | ($urandom_range(99) < 5);
      if ($urandom_range(99) < 4) begin
        if ($urandom_range(9) == 0) a = 32'hFFFF_FFF0 + $urandom_range(15);
        else a = $urandom_range(1023);
        redirect(a);
      end else begin
        cyc();
      end
    end
    StallDecode = 1'b0; StallFetch = 1'b0;
    ready_pct = 100;
    repeat (12) cyc();
    chk("random_progress", {31'd0, (loads_total > 100)}, 32'd1);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("fetchcnt_matches", FetchCount, loads_since_rst);
`endif

    // Reset in the middle of an outstanding request.
    lat = 4;
    n0 = req_log.size();
    wait_req(n0, "rst_req", a);
    cyc();
    #1;
    rst = 1'b1;
    mon_en = 1'b0;
    #1;
    reset_checks("midrst");
    chk("midrst_busy", {31'd0, FetchBusy}, 32'd1);
    cyc();
    cyc();
    rst = 1'b0;
    lat = 1;
    model_restart(32'h0);
    model_topup();
    loads_since_rst = 0;
    mon_en = 1'b1;
    chk("midrst_reqvld_low", {31'd0, ImemReqValid}, 32'd0);
    repeat (20) cyc();
    chk("restart_progress", {31'd0, (loads_since_rst >= 8)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
